// File: rtl/mul_pkg.sv
// Shared types, widths and helpers for the iterative byte-sliced multiplier.
package mul_pkg;

   localparam int unsigned LANE_W = 8;
   localparam int unsigned LANES  = 4;
   localparam int unsigned OP_W   = LANE_W * LANES;
   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned PP_W   = 2 * LANE_W;
   localparam int unsigned NUM_PP = LANES * LANES;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned SH_W   = 6;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } op_pair_t;

   // Bit offset of the byte-pair partial product a[i]*b[j] within the result.
   function automatic logic [SH_W-1:0] pp_shift(input logic [1:0] i, input logic [1:0] j);
      return SH_W'(LANE_W * (32'(i) + 32'(j)));
   endfunction

endpackage

// File: rtl/array_8.sv
// Combinational 8x8 unsigned array multiplier (shift-and-add rows).
module array_8
   import mul_pkg::*;
(
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [PP_W-1:0]   p_c
);

   always_comb begin
      p_c = '0;
      for (int unsigned r = 0; r < LANE_W; r++) begin
         if (b[r]) p_c = p_c + (PP_W'(a) << r);
      end
   end

endmodule

// File: rtl/mul_acc64.sv
// 64-bit product accumulator: synchronous clear or add of a shifted partial product.
module mul_acc64
   import mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add,
   input  logic [PP_W-1:0]   pp,
   input  logic [SH_W-1:0]   shift,
   output logic [PROD_W-1:0] acc
);

   logic [PROD_W-1:0] sum_c;

   assign sum_c = acc + (PROD_W'(pp) << shift);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add) begin
         acc <= sum_c;
      end
   end

endmodule

// File: rtl/array_mul_seq_ctrl.sv
// Iterative 32x32 unsigned multiplier: one shared 8x8 array walks all 16 byte pairs
// into a 64-bit accumulator, with valid/ready handshakes on both sides.
module array_mul_seq_ctrl
   import mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   op_pair_t          ops_q, ops_d;
   logic              acc_clr_c, acc_add_c;
   logic [1:0]        lane_i_c, lane_j_c;
   logic [LANE_W-1:0] lane_a_c, lane_b_c;
   logic [PP_W-1:0]   pp_c;
   logic [SH_W-1:0]   shift_c;
   logic [PROD_W-1:0] acc;

   // idx[1:0] walks multiplicand bytes, idx[3:2] walks multiplier bytes.
   assign lane_i_c = idx_q[1:0];
   assign lane_j_c = idx_q[3:2];
   assign lane_a_c = LANE_W'(ops_q.a >> (LANE_W * 32'(lane_i_c)));
   assign lane_b_c = LANE_W'(ops_q.b >> (LANE_W * 32'(lane_j_c)));
   assign shift_c  = pp_shift(lane_i_c, lane_j_c);

   array_8 u_array_8 (
      .a   (lane_a_c),
      .b   (lane_b_c),
      .p_c (pp_c)
   );

   mul_acc64 u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr_c),
      .add   (acc_add_c),
      .pp    (pp_c),
      .shift (shift_c),
      .acc   (acc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ops_d     = ops_q;
      acc_clr_c = 1'b0;
      acc_add_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               ops_d     = '{a: in_a, b: in_b};
               idx_d     = '0;
               acc_clr_c = 1'b1;
               // A zero operand skips the byte walk: the cleared acc is already the product.
               state_d   = ((in_a == '0) || (in_b == '0)) ? DONE : CALC;
            end
         end
         CALC: begin
            acc_add_c = 1'b1;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         ops_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ops_q     <= ops_d;
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         busy      <= (state_d != IDLE);
      end
   end

   assign out_p = acc;

endmodule
